// File: rtl/fft_sample_loader_if.sv
// Sample stream from the loader to the FFT core.
//   valid : word on data/index/last is presented
//   ready : core accepts the word this cycle
//   data  : sample, two's complement
//   index : frame position of the sample
//   last  : final word of the frame
interface fft_sample_loader_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned IDX_W  = 4
) ();
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [IDX_W-1:0]  index;
  logic              last;

  modport master (output valid, data, index, last, input ready);
  modport slave  (input valid, data, index, last, output ready);
endinterface

// File: rtl/fft_sample_loader.sv
// Operator sample entry and frame streamer for the FFT core.
// Samples are assembled hi byte then lo byte from the switches, stored in a
// frame buffer, and on commit streamed as a full zero-padded frame.
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_sw           : switch byte
//   i_enter        : latch i_sw into the next byte of the sample
//   i_commit       : start streaming the frame
//   i_clear        : discard the frame, return to entry
//   o_stream       : valid/ready sample stream (master side)
//   o_count        : samples entered, 0..N_SAMPLES
//   o_display      : sample being assembled, for the seven-segment display
//   o_full         : o_count == N_SAMPLES
//   o_streaming    : frame transfer in progress
//   o_frame_done   : frame fully transferred, held until clear
module fft_sample_loader #(
  parameter int unsigned N_SAMPLES = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic [7:0]              i_sw,
  input  logic                    i_enter,
  input  logic                    i_commit,
  input  logic                    i_clear,
  fft_sample_loader_if.master     o_stream,
  output logic [IDX_W:0]          o_count,
  output logic [15:0]             o_display,
  output logic                    o_full,
  output logic                    o_streaming,
  output logic                    o_frame_done
);

  localparam int unsigned CNT_W = IDX_W + 1;

  typedef enum logic [2:0] {
    S_ENTER_HI,
    S_ENTER_LO,
    S_FULL,
    S_STREAM,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0] r_buf [N_SAMPLES];
  logic [CNT_W-1:0]  r_count;
  logic [15:0]       r_display;
  logic              r_full;
  logic              r_streaming;
  logic              r_frame_done;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [IDX_W-1:0]  r_out_index;
  logic              r_out_last;

  logic              w_load_hi;
  logic              w_load_lo;
  logic              w_start;
  logic              w_xfer;
  logic              w_clear;
  logic [CNT_W-1:0]  w_count_inc;
  logic              w_hit_full;
  logic [IDX_W-1:0]  w_rd_next;
  logic [DATA_W-1:0] w_rd_data;

  assign w_count_inc = r_count + CNT_W'(1);
  assign w_hit_full  = (w_count_inc == CNT_W'(N_SAMPLES));

  // Next word to present: index 0 on start, else the one after the current.
  assign w_rd_next = w_start ? '0 : r_out_index + IDX_W'(1);
  // Slots beyond the entered count pad the frame with zeros.
  assign w_rd_data = ({1'b0, w_rd_next} < r_count) ? r_buf[w_rd_next] : '0;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_ENTER_HI;
    else          r_state <= w_state_next;
  end

  // Next state and datapath strobes; clear beats commit beats enter.
  always_comb begin
    w_state_next = r_state;
    w_load_hi    = 1'b0;
    w_load_lo    = 1'b0;
    w_start      = 1'b0;
    w_xfer       = 1'b0;
    w_clear      = 1'b0;
    if (i_clear) begin
      w_clear      = 1'b1;
      w_state_next = S_ENTER_HI;
    end else begin
      case (r_state)
        S_ENTER_HI: begin
          if (i_commit) begin
            if (r_count != '0) begin
              w_start      = 1'b1;
              w_state_next = S_STREAM;
            end
          end else if (i_enter) begin
            w_load_hi    = 1'b1;
            w_state_next = S_ENTER_LO;
          end
        end
        S_ENTER_LO: begin
          // A half-assembled sample is never streamed, so commit is dropped.
          if (!i_commit && i_enter) begin
            w_load_lo    = 1'b1;
            w_state_next = w_hit_full ? S_FULL : S_ENTER_HI;
          end
        end
        S_FULL: begin
          if (i_commit) begin
            w_start      = 1'b1;
            w_state_next = S_STREAM;
          end
        end
        S_STREAM: begin
          if (r_out_valid && o_stream.ready) begin
            w_xfer = 1'b1;
            if (r_out_last) w_state_next = S_DONE;
          end
        end
        S_DONE:  w_state_next = S_DONE;
        default: w_state_next = S_ENTER_HI;
      endcase
    end
  end

  // Frame buffer; deliberately not reset, stale entries are masked by count.
  always_ff @(posedge i_clk) begin
    if (w_load_lo) r_buf[r_count[IDX_W-1:0]] <= DATA_W'({r_display[15:8], i_sw});
  end

  // Entry, status and stream output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count      <= '0;
      r_display    <= '0;
      r_full       <= 1'b0;
      r_streaming  <= 1'b0;
      r_frame_done <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_index  <= '0;
      r_out_last   <= 1'b0;
    end else begin
      r_streaming  <= (w_state_next == S_STREAM);
      r_frame_done <= (w_state_next == S_DONE);
      if (w_clear) begin
        r_count     <= '0;
        r_display   <= '0;
        r_full      <= 1'b0;
        r_out_valid <= 1'b0;
        r_out_data  <= '0;
        r_out_index <= '0;
        r_out_last  <= 1'b0;
      end else begin
        if (w_load_hi) r_display <= {i_sw, 8'h00};
        if (w_load_lo) begin
          r_display[7:0] <= i_sw;
          r_count        <= w_count_inc;
          r_full         <= w_hit_full;
        end
        // Words only change on start or transfer, so a stall holds them.
        if (w_start || (w_xfer && !r_out_last)) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_rd_data;
          r_out_index <= w_rd_next;
          r_out_last  <= (w_rd_next == IDX_W'(N_SAMPLES - 1));
        end else if (w_xfer) begin
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
        end
      end
    end
  end

  assign o_stream.valid = r_out_valid;
  assign o_stream.data  = r_out_data;
  assign o_stream.index = r_out_index;
  assign o_stream.last  = r_out_last;
  assign o_count        = r_count;
  assign o_display      = r_display;
  assign o_full         = r_full;
  assign o_streaming    = r_streaming;
  assign o_frame_done   = r_frame_done;

endmodule

// File: tb/tb_fft_sample_loader.sv
// Self-checking bench for fft_sample_loader: scoreboard of expected frame
// words pushed at commit, popped on each observed transfer.
module tb_fft_sample_loader;

  localparam int unsigned N  = 16;
  localparam int unsigned DW = 16;
  localparam int unsigned IW = 4;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    sw    = 8'h00;
  logic          enter = 1'b0;
  logic          commit = 1'b0;
  logic          clear = 1'b0;
  logic [IW:0]   count;
  logic [15:0]   display;
  logic          full;
  logic          streaming;
  logic          frame_done;

  fft_sample_loader_if #(.DATA_W(DW), .IDX_W(IW)) u_if ();

  fft_sample_loader #(.N_SAMPLES(N), .DATA_W(DW), .IDX_W(IW)) u_dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_sw         (sw),
    .i_enter      (enter),
    .i_commit     (commit),
    .i_clear      (clear),
    .o_stream     (u_if),
    .o_count      (count),
    .o_display    (display),
    .o_full       (full),
    .o_streaming  (streaming),
    .o_frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [IW-1:0] index;
    logic          last;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] model_buf [N];
  int          model_count = 0;
  int          n_checks = 0;
  int          n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enter_byte(input logic [7:0] v);
    sw = v; enter = 1'b1; tick(); enter = 1'b0;
  endtask

  task automatic enter_sample(input logic [15:0] s);
    enter_byte(s[15:8]);
    enter_byte(s[7:0]);
    if (model_count < N) begin
      model_buf[model_count] = s;
      model_count++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1; tick(); clear = 1'b0;
    model_count = 0;
    sb.delete();
  endtask

  task automatic push_frame();
    exp_t e;
    for (int i = 0; i < N; i++) begin
      e.data  = (i < model_count) ? model_buf[i] : '0;
      e.index = IW'(i);
      e.last  = (i == N - 1);
      sb.push_back(e);
    end
  endtask

  // Commit and drain one frame; stall=1 drives ready 1,0,0,1,0,0,...
  task automatic run_stream(input bit stall, input string tag);
    exp_t e;
    exp_t held;
    bit   stalled = 1'b0;
    int   cycles = 0;
    int   xfers = 0;
    held = '0;
    push_frame();
    commit = 1'b1; tick(); commit = 1'b0;
    while (sb.size() > 0 && cycles < 200) begin
      u_if.ready = stall ? (cycles % 3 == 0) : 1'b1;
      n_checks++;
      if (u_if.valid !== 1'b1) $display("FAIL %s valid: got %b want 1 (cycle %0d)", tag, u_if.valid, cycles);
      else n_pass++;
      if (stalled) begin
        n_checks++;
        if ({u_if.data, u_if.index, u_if.last} !== held)
          $display("FAIL %s stall_hold: got %h/%0d/%b want %h/%0d/%b", tag,
                   u_if.data, u_if.index, u_if.last, held.data, held.index, held.last);
        else n_pass++;
      end
      if (u_if.ready) begin
        e = sb.pop_front();
        n_checks++;
        if (u_if.data !== e.data) $display("FAIL %s data[%0d]: got %h want %h", tag, e.index, u_if.data, e.data);
        else n_pass++;
        n_checks++;
        if (u_if.index !== e.index) $display("FAIL %s index: got %0d want %0d", tag, u_if.index, e.index);
        else n_pass++;
        n_checks++;
        if (u_if.last !== e.last) $display("FAIL %s last[%0d]: got %b want %b", tag, e.index, u_if.last, e.last);
        else n_pass++;
        xfers++;
        stalled = 1'b0;
      end else begin
        stalled    = 1'b1;
        held.data  = u_if.data;
        held.index = u_if.index;
        held.last  = u_if.last;
      end
      tick();
      cycles++;
    end
    u_if.ready = 1'b0;
    n_checks++;
    if (xfers != N) $display("FAIL %s xfers: got %0d want %0d", tag, xfers, N);
    else n_pass++;
    if (!stall) begin
      n_checks++;
      if (cycles != N) $display("FAIL %s cycles: got %0d want %0d", tag, cycles, N);
      else n_pass++;
    end
    n_checks++;
    if ({u_if.valid, u_if.last, streaming, frame_done} !== 4'b0001)
      $display("FAIL %s end_state: got v=%b l=%b s=%b d=%b want v=0 l=0 s=0 d=1", tag,
               u_if.valid, u_if.last, streaming, frame_done);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({count, display} !== 21'd0) $display("FAIL reset count/display: got %0d/%h want 0/0", count, display);
    else n_pass++;
    n_checks++;
    if ({u_if.valid, u_if.last, full, streaming, frame_done} !== 5'b0)
      $display("FAIL reset flags: got %b want 00000", {u_if.valid, u_if.last, full, streaming, frame_done});
    else n_pass++;
    n_checks++;
    if ({u_if.data, u_if.index} !== 20'd0) $display("FAIL reset data/index: got %h/%0d want 0/0", u_if.data, u_if.index);
    else n_pass++;
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_enter_pair();
    enter_byte(8'h12);
    n_checks++;
    if (display !== 16'h1200) $display("FAIL pair hi display: got %h want 1200", display);
    else n_pass++;
    n_checks++;
    if (count !== 5'd0) $display("FAIL pair hi count: got %0d want 0", count);
    else n_pass++;
    enter_byte(8'h34);
    model_buf[0] = 16'h1234; model_count = 1;
    n_checks++;
    if (display !== 16'h1234) $display("FAIL pair lo display: got %h want 1234", display);
    else n_pass++;
    n_checks++;
    if (count !== 5'd1) $display("FAIL pair lo count: got %0d want 1", count);
    else n_pass++;
    run_stream(1'b0, "pair");
    do_clear();
  endtask

  task automatic test_stream_basic();
    enter_sample(16'h0001);
    enter_sample(16'h7FFF);
    enter_sample(16'h8000);
    run_stream(1'b0, "basic");
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    n_checks++;
    if ({u_if.valid, streaming, frame_done} !== 3'b001)
      $display("FAIL done_recommit: got v=%b s=%b d=%b want v=0 s=0 d=1", u_if.valid, streaming, frame_done);
    else n_pass++;
    do_clear();
    n_checks++;
    if (frame_done !== 1'b0) $display("FAIL clear frame_done: got %b want 0", frame_done);
    else n_pass++;
  endtask

  task automatic test_back_to_back_stall();
    enter_sample(16'h0001);
    enter_sample(16'h7FFF);
    enter_sample(16'h8000);
    run_stream(1'b1, "stall");
    do_clear();
  endtask

  task automatic test_full();
    logic [15:0] last_s;
    for (int i = 0; i < N; i++) enter_sample(16'($urandom()));
    last_s = model_buf[N-1];
    n_checks++;
    if ({full, count} !== {1'b1, 5'd16}) $display("FAIL full: got full=%b count=%0d want 1/16", full, count);
    else n_pass++;
    enter_sample(16'hDEAD);
    n_checks++;
    if (count !== 5'd16) $display("FAIL overflow count: got %0d want 16", count);
    else n_pass++;
    n_checks++;
    if (display !== last_s) $display("FAIL overflow display: got %h want %h", display, last_s);
    else n_pass++;
    run_stream(1'b0, "full");
    do_clear();
  endtask

  task automatic test_commit_ignored();
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    n_checks++;
    if ({u_if.valid, streaming} !== 2'b00) $display("FAIL commit_empty: got v=%b s=%b want 0/0", u_if.valid, streaming);
    else n_pass++;
    enter_byte(8'h55);
    commit = 1'b1; tick(); commit = 1'b0;
    tick();
    n_checks++;
    if ({u_if.valid, streaming} !== 2'b00) $display("FAIL commit_lo: got v=%b s=%b want 0/0", u_if.valid, streaming);
    else n_pass++;
    enter_byte(8'h66);
    model_buf[0] = 16'h5566; model_count = 1;
    n_checks++;
    if ({count, display} !== {5'd1, 16'h5566}) $display("FAIL commit_lo resume: got %0d/%h want 1/5566", count, display);
    else n_pass++;
  endtask

  task automatic test_clear_mid_stream();
    exp_t e;
    int   guard = 0;
    push_frame();
    commit = 1'b1; tick(); commit = 1'b0;
    u_if.ready = 1'b1;
    while (u_if.index != IW'(5) && guard < 40) begin
      e = sb.pop_front();
      n_checks++;
      if (u_if.data !== e.data) $display("FAIL abort data[%0d]: got %h want %h", e.index, u_if.data, e.data);
      else n_pass++;
      tick();
      guard++;
    end
    u_if.ready = 1'b0;
    n_checks++;
    if ({u_if.valid, u_if.index} !== {1'b1, 4'd5}) $display("FAIL abort reach: got v=%b idx=%0d want 1/5", u_if.valid, u_if.index);
    else n_pass++;
    do_clear();
    n_checks++;
    if ({u_if.valid, u_if.last, streaming, frame_done, full} !== 5'b0)
      $display("FAIL abort flags: got %b want 00000", {u_if.valid, u_if.last, streaming, frame_done, full});
    else n_pass++;
    n_checks++;
    if ({count, display} !== 21'd0) $display("FAIL abort count/display: got %0d/%h want 0/0", count, display);
    else n_pass++;
  endtask

  task automatic test_clear_priority();
    enter_sample(16'hABCD);
    sw = 8'h99; enter = 1'b1; commit = 1'b1; clear = 1'b1;
    tick();
    enter = 1'b0; commit = 1'b0; clear = 1'b0;
    model_count = 0;
    n_checks++;
    if ({count, display} !== 21'd0) $display("FAIL prio count/display: got %0d/%h want 0/0", count, display);
    else n_pass++;
    n_checks++;
    if ({u_if.valid, streaming} !== 2'b00) $display("FAIL prio stream: got v=%b s=%b want 0/0", u_if.valid, streaming);
    else n_pass++;
    tick();
    n_checks++;
    if ({u_if.valid, display} !== 17'd0) $display("FAIL prio settle: got v=%b disp=%h want 0/0", u_if.valid, display);
    else n_pass++;
  endtask

  initial begin
    u_if.ready = 1'b0;
    test_reset();
    test_enter_pair();
    test_stream_basic();
    test_back_to_back_stall();
    test_full();
    test_commit_ignored();
    test_clear_mid_stream();
    test_clear_priority();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
